// File: rtl/csr_pkg.sv
// Shared widths and the speculative CSR write entry layout for the CSR
// speculation buffer and its lookup logic.
package csr_pkg;
    localparam int CSR_ADDR_W = 14;
    localparam int CSR_DATA_W = 32;

    typedef struct packed {
        logic                  valid;
        logic [CSR_ADDR_W-1:0] addr;
        logic [CSR_DATA_W-1:0] data;
    } csr_wr_entry_t;
endpackage

// File: rtl/csr_spec_buf_if.sv
// Enqueue handshake, read-bypass lookup and retired-write ports of the
// CSR speculation buffer; slave is the buffer, master is its environment.
interface csr_spec_buf_if #(
    parameter int NUM_RD   = 2,
    parameter int COMMIT_W = 2
);
    logic                                          enq_valid;
    logic                                          enq_ready;
    logic [csr_pkg::CSR_ADDR_W-1:0]                enq_addr;
    logic [csr_pkg::CSR_DATA_W-1:0]                enq_data;
    logic [NUM_RD-1:0][csr_pkg::CSR_ADDR_W-1:0]    rd_addr;
    logic [NUM_RD-1:0]                             rd_hit;
    logic [NUM_RD-1:0][csr_pkg::CSR_DATA_W-1:0]    rd_data;
    logic [COMMIT_W-1:0]                           cwr_en;
    logic [COMMIT_W-1:0][csr_pkg::CSR_ADDR_W-1:0]  cwr_addr;
    logic [COMMIT_W-1:0][csr_pkg::CSR_DATA_W-1:0]  cwr_data;

    modport master (
        output enq_valid, enq_addr, enq_data, rd_addr,
        input  enq_ready, rd_hit, rd_data, cwr_en, cwr_addr, cwr_data
    );

    modport slave (
        input  enq_valid, enq_addr, enq_data, rd_addr,
        output enq_ready, rd_hit, rd_data, cwr_en, cwr_addr, cwr_data
    );
endinterface

// File: rtl/csr_buf_searcher.sv
// One priority lookup: youngest valid buffer entry first, then the retired
// write stage from its highest port down to port 0.
module csr_buf_searcher
    import csr_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int COMMIT_W = 2,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  csr_wr_entry_t                         entries [DEPTH],
    input  logic [PTR_W-1:0]                      head,
    input  logic [CNT_W-1:0]                      count,
    input  logic [COMMIT_W-1:0]                   cwr_en,
    input  logic [COMMIT_W-1:0][CSR_ADDR_W-1:0]   cwr_addr,
    input  logic [COMMIT_W-1:0][CSR_DATA_W-1:0]   cwr_data,
    input  logic [CSR_ADDR_W-1:0]                 addr,
    output logic                                  hit,
    output logic [CSR_DATA_W-1:0]                 data
);
    // Lowest priority is scanned first so later matches override earlier ones.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int k = 0; k < COMMIT_W; k++) begin
            if (cwr_en[k] && cwr_addr[k] == addr) begin
                hit  = 1'b1;
                data = cwr_data[k];
            end
        end
        for (int j = 0; j < DEPTH; j++) begin
            if (CNT_W'(j) < count &&
                entries[head + PTR_W'(j)].valid &&
                entries[head + PTR_W'(j)].addr == addr) begin
                hit  = 1'b1;
                data = entries[head + PTR_W'(j)].data;
            end
        end
    end
endmodule

// File: rtl/csr_spec_buf.sv
// Speculative CSR write buffer: in-order circular queue of executed CSR
// writes, retired to a registered write stage, with read bypass ports.
module csr_spec_buf
    import csr_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int NUM_RD    = 2,
    parameter int COMMIT_W  = 2,
    parameter int AF_THRESH = DEPTH - 2,
    localparam int PTR_W    = $clog2(DEPTH),
    localparam int CNT_W    = $clog2(DEPTH + 1),
    localparam int CC_W     = $clog2(COMMIT_W + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic [CC_W-1:0]    commit_cnt,
    csr_spec_buf_if.slave      bus,
    output logic [CNT_W-1:0]   count,
    output logic               empty,
    output logic               almost_full,
    output logic               commit_err
);
    csr_wr_entry_t                        mem_reg [DEPTH];
    logic [PTR_W-1:0]                     head_reg, tail_reg;
    logic [CNT_W-1:0]                     count_reg, count_next;
    logic [COMMIT_W-1:0]                  cwr_en_reg;
    logic [COMMIT_W-1:0][CSR_ADDR_W-1:0]  cwr_addr_reg;
    logic [COMMIT_W-1:0][CSR_DATA_W-1:0]  cwr_data_reg;
    logic                                 commit_err_reg;

    logic [CNT_W-1:0]  cc_ext, pops;
    logic              enq_fire;
    logic [DEPTH-1:0]  pop_mask;
    logic [NUM_RD-1:0]                  rd_hit_w;
    logic [NUM_RD-1:0][CSR_DATA_W-1:0]  rd_data_w;

    assign cc_ext        = CNT_W'(commit_cnt);
    assign pops          = (cc_ext > count_reg) ? count_reg : cc_ext;
    assign bus.enq_ready = (count_reg < CNT_W'(DEPTH)) && !flush;
    assign enq_fire      = bus.enq_valid && bus.enq_ready;
    assign count_next    = flush ? '0 : count_reg + CNT_W'(enq_fire) - pops;

    // An entry is popped when its age relative to head falls below the pop count.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
            logic [PTR_W-1:0] age;
            assign age          = PTR_W'(gi) - head_reg;
            assign pop_mask[gi] = CNT_W'(age) < pops;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_reg       <= '0;
            tail_reg       <= '0;
            count_reg      <= '0;
            cwr_en_reg     <= '0;
            cwr_addr_reg   <= '0;
            cwr_data_reg   <= '0;
            commit_err_reg <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (flush || pop_mask[i])
                    mem_reg[i].valid <= 1'b0;
                else if (enq_fire && tail_reg == PTR_W'(i))
                    mem_reg[i] <= '{valid: 1'b1, addr: bus.enq_addr, data: bus.enq_data};
            end
            // Retiring entries move to the write stage even on a flush cycle.
            for (int k = 0; k < COMMIT_W; k++) begin
                cwr_en_reg[k] <= CNT_W'(k) < pops;
                if (CNT_W'(k) < pops) begin
                    cwr_addr_reg[k] <= mem_reg[head_reg + PTR_W'(k)].addr;
                    cwr_data_reg[k] <= mem_reg[head_reg + PTR_W'(k)].data;
                end
            end
            head_reg  <= flush ? tail_reg : head_reg + PTR_W'(pops);
            tail_reg  <= tail_reg + PTR_W'(enq_fire);
            count_reg <= count_next;
            if (cc_ext > count_reg) commit_err_reg <= 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
            csr_buf_searcher #(
                .DEPTH    (DEPTH),
                .COMMIT_W (COMMIT_W)
            ) u_searcher (
                .entries  (mem_reg),
                .head     (head_reg),
                .count    (count_reg),
                .cwr_en   (cwr_en_reg),
                .cwr_addr (cwr_addr_reg),
                .cwr_data (cwr_data_reg),
                .addr     (bus.rd_addr[gi]),
                .hit      (rd_hit_w[gi]),
                .data     (rd_data_w[gi])
            );
        end
    endgenerate

    assign bus.rd_hit   = rd_hit_w;
    assign bus.rd_data  = rd_data_w;
    assign bus.cwr_en   = cwr_en_reg;
    assign bus.cwr_addr = cwr_addr_reg;
    assign bus.cwr_data = cwr_data_reg;
    assign count        = count_reg;
    assign empty        = (count_reg == '0);
    assign almost_full  = (count_reg >= CNT_W'(AF_THRESH));
    assign commit_err   = commit_err_reg;
endmodule

// File: tb/tb_csr_spec_buf.sv
// Randomized and directed bench for csr_spec_buf against a queue-based
// reference model of the speculative CSR write buffer.
module tb_csr_spec_buf;
    localparam int DEPTH    = 16;
    localparam int NUM_RD   = 2;
    localparam int COMMIT_W = 2;

    typedef struct {
        logic [13:0] addr;
        logic [31:0] data;
    } ent_t;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [1:0]  commit_cnt;
    logic [4:0]  count;
    logic        empty, almost_full, commit_err;

    csr_spec_buf_if #(.NUM_RD(NUM_RD), .COMMIT_W(COMMIT_W)) bus ();

    csr_spec_buf #(
        .DEPTH    (DEPTH),
        .NUM_RD   (NUM_RD),
        .COMMIT_W (COMMIT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .commit_cnt  (commit_cnt),
        .bus         (bus),
        .count       (count),
        .empty       (empty),
        .almost_full (almost_full),
        .commit_err  (commit_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    // Reference model state
    ent_t        q[$];
    bit          m_en   [COMMIT_W];
    logic [13:0] m_addr [COMMIT_W];
    logic [31:0] m_data [COMMIT_W];
    bit          m_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_rd(input logic [13:0] a, output bit h, output logic [31:0] d);
        h = 1'b0;
        d = '0;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].addr == a) begin
                h = 1'b1;
                d = q[i].data;
                return;
            end
        end
        for (int k = COMMIT_W - 1; k >= 0; k--) begin
            if (m_en[k] && m_addr[k] == a) begin
                h = 1'b1;
                d = m_data[k];
                return;
            end
        end
    endfunction

    function automatic void model_reset();
        q.delete();
        for (int k = 0; k < COMMIT_W; k++) begin
            m_en[k]   = 1'b0;
            m_addr[k] = '0;
            m_data[k] = '0;
        end
        m_err = 1'b0;
    endfunction

    task automatic check_comb();
        bit          h;
        logic [31:0] d;
        chk("enq_ready", bus.enq_ready, (q.size() < DEPTH) && !flush);
        chk("empty", empty, q.size() == 0);
        chk("almost_full", almost_full, q.size() >= DEPTH - 2);
        for (int p = 0; p < NUM_RD; p++) begin
            model_rd(bus.rd_addr[p], h, d);
            chk($sformatf("rd_hit%0d", p), bus.rd_hit[p], h);
            if (h) chk($sformatf("rd_data%0d", p), bus.rd_data[p], d);
        end
    endtask

    // One clock: drive, check pre-edge outputs, advance model, check registered outputs.
    task automatic step(input bit ev, input logic [13:0] ea, input logic [31:0] ed,
                        input int cc, input bit fl);
        int sz, pops;
        bit acc;
        bus.enq_valid = ev;
        bus.enq_addr  = ea;
        bus.enq_data  = ed;
        commit_cnt    = 2'(cc);
        flush         = fl;
        #1;
        check_comb();
        @(posedge clk);
        sz   = q.size();
        pops = (cc < sz) ? cc : sz;
        acc  = ev && (sz < DEPTH) && !fl;
        if (cc > sz) m_err = 1'b1;
        for (int k = 0; k < COMMIT_W; k++) begin
            m_en[k] = (k < pops);
            if (k < pops) begin
                m_addr[k] = q[k].addr;
                m_data[k] = q[k].data;
            end
        end
        for (int k = 0; k < pops; k++) void'(q.pop_front());
        if (fl) q.delete();
        else if (acc) q.push_back('{ea, ed});
        #1;
        chk("count", count, q.size());
        chk("commit_err", commit_err, m_err);
        for (int k = 0; k < COMMIT_W; k++) begin
            chk($sformatf("cwr_en%0d", k), bus.cwr_en[k], m_en[k]);
            if (m_en[k]) begin
                chk($sformatf("cwr_addr%0d", k), bus.cwr_addr[k], m_addr[k]);
                chk($sformatf("cwr_data%0d", k), bus.cwr_data[k], m_data[k]);
            end
        end
        $display("t=%0t enq=%0d addr=%0h data=%0h cc=%0d flush=%0d -> count=%0d cwr_en=%b err=%0d",
                 $time, ev, ea, ed, cc, fl, count, bus.cwr_en, commit_err);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_empty"}, empty, 1);
        chk({tag, "_af"}, almost_full, 0);
        chk({tag, "_ready"}, bus.enq_ready, 1);
        chk({tag, "_err"}, commit_err, 0);
        chk({tag, "_cwr_en"}, bus.cwr_en, 0);
        chk({tag, "_cwr_addr0"}, bus.cwr_addr[0], 0);
        chk({tag, "_cwr_data0"}, bus.cwr_data[0], 0);
        chk({tag, "_cwr_addr1"}, bus.cwr_addr[1], 0);
        chk({tag, "_cwr_data1"}, bus.cwr_data[1], 0);
        chk({tag, "_rd_hit"}, bus.rd_hit, 0);
    endtask

    task automatic rand_steps(input int n);
        for (int i = 0; i < n; i++) begin
            for (int p = 0; p < NUM_RD; p++) bus.rd_addr[p] = 14'($urandom_range(0, 7));
            step($urandom_range(0, 3) != 0, 14'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 2), $urandom_range(0, 19) == 0);
        end
    endtask

    initial begin
        rst           = 1'b0;
        flush         = 1'b0;
        commit_cnt    = '0;
        bus.enq_valid = 1'b0;
        bus.enq_addr  = '0;
        bus.enq_data  = '0;
        bus.rd_addr[0] = 14'h006;
        bus.rd_addr[1] = 14'h00C;
        model_reset();
        #3;
        check_reset_values("rst0");
        #9;
        rst = 1'b1;

        // Single write retires to port 0 one cycle after commit
        step(1'b1, 14'h006, 32'h1C000100, 0, 1'b0);
        step(1'b0, '0, '0, 1, 1'b0);
        chk("r31_en", bus.cwr_en, 2'b01);
        chk("r31_addr", bus.cwr_addr[0], 14'h006);
        chk("r31_data", bus.cwr_data[0], 32'h1C000100);
        chk("r31_count", count, 0);
        step(1'b0, '0, '0, 0, 1'b0);

        // Youngest write to the same CSR wins, including through the cwr stage
        bus.rd_addr[0] = 14'h00C;
        step(1'b1, 14'h00C, 32'h100, 0, 1'b0);
        step(1'b1, 14'h00C, 32'h200, 0, 1'b0);
        chk("r32_hit_a", bus.rd_hit[0], 1);
        chk("r32_data_a", bus.rd_data[0], 32'h200);
        step(1'b0, '0, '0, 1, 1'b0);
        chk("r32_data_b", bus.rd_data[0], 32'h200);
        step(1'b0, '0, '0, 1, 1'b0);
        chk("r32_hit_c", bus.rd_hit[0], 1);
        chk("r32_data_c", bus.rd_data[0], 32'h200);
        step(1'b0, '0, '0, 0, 1'b0);
        chk("r32_hit_d", bus.rd_hit[0], 0);

        // Full buffer refuses enqueue even alongside a pop; tail wraps
        for (int i = 0; i < DEPTH; i++) step(1'b1, 14'(i), 32'(i * 3 + 1), 0, 1'b0);
        chk("r33_ready", bus.enq_ready, 0);
        chk("r33_af", almost_full, 1);
        step(1'b1, 14'h3F, 32'hDEAD, 1, 1'b0);
        chk("r33_count15", count, 15);
        step(1'b1, 14'h3E, 32'hBEEF, 0, 1'b0);
        chk("r33_count16", count, 16);
        for (int i = 0; i < DEPTH / 2; i++) step(1'b0, '0, '0, 2, 1'b0);
        step(1'b0, '0, '0, 0, 1'b0);

        // Flush with a simultaneous commit of two out of three entries
        bus.rd_addr[1] = 14'h012;
        step(1'b1, 14'h010, 32'hA0, 0, 1'b0);
        step(1'b1, 14'h011, 32'hA1, 0, 1'b0);
        step(1'b1, 14'h012, 32'hA2, 0, 1'b0);
        step(1'b0, '0, '0, 2, 1'b1);
        chk("r34_en", bus.cwr_en, 2'b11);
        chk("r34_addr0", bus.cwr_addr[0], 14'h010);
        chk("r34_addr1", bus.cwr_addr[1], 14'h011);
        chk("r34_count", count, 0);
        step(1'b0, '0, '0, 0, 1'b0);
        chk("r34_hit", bus.rd_hit[1], 0);

        rand_steps(400);

        // Over-commit sets a sticky error
        step(1'b0, '0, '0, 0, 1'b1);
        step(1'b1, 14'h020, 32'h55, 0, 1'b0);
        step(1'b0, '0, '0, 2, 1'b0);
        chk("r35_en", bus.cwr_en, 2'b01);
        chk("r35_err", commit_err, 1);
        rand_steps(20);
        chk("r35_err_sticky", commit_err, 1);

        // Asynchronous reset in the middle of filling
        for (int i = 0; i < 5; i++) step(1'b1, 14'(i), $urandom, i % 2, 1'b0);
        bus.enq_valid = 1'b0;
        commit_cnt    = '0;
        flush         = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check_reset_values("rst_mid");
        model_reset();
        #2;
        rst = 1'b1;
        step(1'b0, '0, '0, 0, 1'b0);
        rand_steps(100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
